// File: rtl/reset_pulse_gen.sv
// Generates a registered, active-low reset pulse at least RSTHOLD cycles long from a request.
// Optional DONE strobe on pulse release when RESET_PULSE_GEN_DONE_EN is defined.
module reset_pulse_gen #(
  parameter int unsigned RSTHOLD = 2,
  parameter int unsigned CW      = 4,
  parameter bit          INIT    = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic ASSERT_IN,
  output logic RST_OUT,
  output logic BUSY
`ifdef RESET_PULSE_GEN_DONE_EN
  ,
  output logic DONE
`endif
);

  localparam logic [CW-1:0] LAST = CW'(RSTHOLD - 1);

  // Reject hold lengths the counter cannot represent.
  if (RSTHOLD == 0 || RSTHOLD >= (32'd1 << CW)) begin : g_bad_rsthold
    $error("reset_pulse_gen: RSTHOLD must be in 1..2^CW-1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_out_q, rst_out_d;
  logic          busy_q;
`ifdef RESET_PULSE_GEN_DONE_EN
  logic          done_q, done_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= INIT ? HOLD : IDLE;
      cnt_q     <= '0;
      rst_out_q <= ~INIT;
      busy_q    <= INIT;
`ifdef RESET_PULSE_GEN_DONE_EN
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      busy_q    <= ~rst_out_d;
`ifdef RESET_PULSE_GEN_DONE_EN
      done_q    <= done_d;
`endif
    end
  end

  // A request in HOLD restarts the count, extending the pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
`ifdef RESET_PULSE_GEN_DONE_EN
    done_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        rst_out_d = 1'b1;
        if (ASSERT_IN) begin
          state_d   = HOLD;
          cnt_d     = '0;
          rst_out_d = 1'b0;
        end
      end
      HOLD: begin
        rst_out_d = 1'b0;
        if (ASSERT_IN) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          rst_out_d = 1'b1;
`ifdef RESET_PULSE_GEN_DONE_EN
          done_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        rst_out_d = 1'b1;
      end
    endcase
  end

  assign RST_OUT = rst_out_q;
  assign BUSY    = busy_q;
`ifdef RESET_PULSE_GEN_DONE_EN
  assign DONE    = done_q;
`endif

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Drives several reset_pulse_gen configurations with one shared stimulus stream and
// scores each against an age-since-last-request reference model.
module tb_reset_pulse_gen;

  localparam int unsigned N   = 5;
  localparam int unsigned SAT = 1000;

  function automatic int unsigned hold_of(input int unsigned i);
    case (i)
      0: hold_of = 3;
      1: hold_of = 3;
      2: hold_of = 4;
      3: hold_of = 1;
      default: hold_of = 2;
    endcase
  endfunction

  function automatic int unsigned init_of(input int unsigned i);
    init_of = (i == 0 || i == 4) ? 1 : 0;
  endfunction

  typedef struct packed {
    logic [2:0] idx;
    logic       rst_out;
    logic       busy;
    logic       done;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         assert_in;
  logic [N-1:0] rst_out_w;
  logic [N-1:0] busy_w;
`ifdef RESET_PULSE_GEN_DONE_EN
  logic [N-1:0] done_w;
`endif

  exp_t        sb[$];
  int unsigned age[N];
  bit          prev_low[N];
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < int'(N); g++) begin : g_dut
    reset_pulse_gen #(
      .RSTHOLD(hold_of(g)),
      .CW     (4),
      .INIT   (1'(init_of(g)))
    ) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .ASSERT_IN(assert_in),
      .RST_OUT  (rst_out_w[g]),
      .BUSY     (busy_w[g])
`ifdef RESET_PULSE_GEN_DONE_EN
      ,
      .DONE     (done_w[g])
`endif
    );
  end

  task automatic step(input logic r, input logic a);
    exp_t e;
    bit   low;
    @(negedge clk);
    rst       = r;
    assert_in = a;
    for (int i = 0; i < int'(N); i++) begin
      if (!r) age[i] = (init_of(i) != 0) ? 0 : SAT;
      else if (a) age[i] = 0;
      else if (age[i] < SAT) age[i] = age[i] + 1;
      low       = age[i] < hold_of(i);
      e.idx     = 3'(i);
      e.rst_out = ~low;
      e.busy    = low;
      e.done    = r && prev_low[i] && !low;
      prev_low[i] = low;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (rst_out_w[e.idx] === e.rst_out) else begin
        errors++;
        $error("FAIL rst_out dut%0d t=%0t got %b exp %b", e.idx, $time, rst_out_w[e.idx], e.rst_out);
      end
      checks++;
      assert (busy_w[e.idx] === e.busy) else begin
        errors++;
        $error("FAIL busy dut%0d t=%0t got %b exp %b", e.idx, $time, busy_w[e.idx], e.busy);
      end
`ifdef RESET_PULSE_GEN_DONE_EN
      checks++;
      assert (done_w[e.idx] === e.done) else begin
        errors++;
        $error("FAIL done dut%0d t=%0t got %b exp %b", e.idx, $time, done_w[e.idx], e.done);
      end
`endif
    end
  endtask

  task automatic run(input logic r, input logic a, input int n);
    for (int k = 0; k < n; k++) step(r, a);
  endtask

  initial begin
    rst       = 1'b0;
    assert_in = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      age[i]      = SAT;
      prev_low[i] = 1'b0;
    end
    // Power-on reset, then INIT=1 instances release after their hold.
    run(1'b0, 1'b0, 4);
    run(1'b1, 1'b0, 8);
    // Single request.
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 8);
    // Two requests two edges apart: retrigger, or two pulses for RSTHOLD=1.
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 1);
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 8);
    // Reset arriving one edge after a request.
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 8);
    // Request held high continuously.
    run(1'b1, 1'b1, 20);
    run(1'b1, 1'b0, 8);
    // Mixed random traffic with occasional resets.
    for (int k = 0; k < 80; k++) begin
      step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    run(1'b1, 1'b0, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
